// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop modulo counter.
//   dir_e      : count direction encoding (matches the up_dn pin)
//   last_of    : terminal value helper, LAST = MODULUS-1
//   clamp_load : saturating clamp of a load value into 0..modulus-1
package tff_pkg;

   typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

   function automatic int last_of(input int modulus);
      return modulus - 1;
   endfunction

   function automatic int clamp_load(input int val, input int modulus);
      return (val < modulus) ? val : modulus - 1;
   endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single-bit T flip-flop storage cell.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears q
//   t     : toggle request, q inverts on the edge when high
//   q     : stored bit
module t_ff_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= 1'b0;
      else if (t)  q <= ~q;
   end

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter whose state lives entirely in T flip-flops.
// Every state change (count, wrap, clear, load) is expressed as a toggle
// vector t = count ^ next feeding the cells.
//   clk, rst_n : clock, asynchronous active-low reset
//   en, up_dn  : count enable and direction (1 = up)
//   load       : synchronous load of load_val, clamped to MODULUS-1
//   clr        : synchronous clear (highest priority)
//   ovf_clr    : clears the sticky overflow flag
//   count      : registered count value
//   tc         : combinational terminal count (cascade enable)
//   wrap       : one-cycle strobe in the cycle after a wrap
//   ovf        : sticky overflow, set on every wrap
module tff_mod_counter
   import tff_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam int              LAST_I = last_of(MODULUS);
   localparam logic [WIDTH-1:0] LAST  = LAST_I[WIDTH-1:0];

   generate
      if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
         $error("tff_mod_counter: illegal WIDTH/MODULUS combination");
      end
   endgenerate

   dir_e             dir;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] t_up;
   logic [WIDTH-1:0] t_dn;
   logic [WIDTH-1:0] load_tgt;
   logic [WIDTH-1:0] wrap_tgt;

   assign dir = dir_e'(up_dn);

   assign tc = en & ~clr & ~load &
               ((up_dn & (count == LAST)) | (~up_dn & (count == '0)));

   // Ripple AND-chain: bit i toggles when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      logic all_one;
      logic all_zero;
      t_up     = '0;
      t_dn     = '0;
      all_one  = 1'b1;
      all_zero = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         t_up[i]  = all_one;
         t_dn[i]  = all_zero;
         all_one  = all_one  &  count[i];
         all_zero = all_zero & ~count[i];
      end
   end

   always_comb begin
      int clamped;
      clamped  = clamp_load(int'(load_val), MODULUS);
      load_tgt = clamped[WIDTH-1:0];
      wrap_tgt = (dir == DIR_UP) ? '0 : LAST;
   end

   // The AND-chain never leaves 0..LAST away from the terminal value, so the
   // modulo correction only needs to step in when tc is active.
   always_comb begin
      t = '0;
      if (clr)          t = count;
      else if (load)    t = count ^ load_tgt;
      else if (en) begin
         if (tc)        t = count ^ wrap_tgt;
         else           t = (dir == DIR_UP) ? t_up : t_dn;
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         t_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t[gi]),
            .q     (count[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         wrap <= tc;
         if (tc)           ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

   a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count <= LAST)
      else $error("tff_mod_counter: count out of range");

endmodule

// File: tb/tb_tff_mod_counter.sv
module tb_tff_mod_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, up_dn, load, clr, ovf_clr;
   logic [3:0] load_val;
   logic [3:0] count_10, count_16;
   logic       tc_10, tc_16, wrap_10, wrap_16, ovf_10, ovf_16;

   int checks = 0;
   int errs   = 0;

   // reference model state
   int c10, c16;
   bit o10, o16, w10, w16;

   always #5 clk = ~clk;

   tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .clr(clr), .ovf_clr(ovf_clr),
      .count(count_10), .tc(tc_10), .wrap(wrap_10), .ovf(ovf_10)
   );

   tff_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .clr(clr), .ovf_clr(ovf_clr),
      .count(count_16), .tc(tc_16), .wrap(wrap_16), .ovf(ovf_16)
   );

   typedef struct {
      bit en, up, ld;
      int lv;
      bit clr, oc;
      int ec;
      bit etc, ew, eo;
   } vec_t;

   vec_t tbl[$];

   function automatic void chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   // Behavioural model: the counter as plain modular arithmetic.
   function automatic void mstep(input int m, inout int c, inout bit o,
                                 output bit w, output bit tcx);
      tcx = en && !clr && !load && ((up_dn && c == m - 1) || (!up_dn && c == 0));
      if (clr)       c = 0;
      else if (load) c = (int'(load_val) < m) ? int'(load_val) : m - 1;
      else if (en)   c = up_dn ? (c + 1) % m : (c + m - 1) % m;
      w = tcx;
      if (tcx)          o = 1'b1;
      else if (ovf_clr) o = 1'b0;
   endfunction

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      int n10, n16;
      bit p10, p16, x10, x16, e10, e16;
      n10 = c10; p10 = o10;
      n16 = c16; p16 = o16;
      mstep(10, n10, p10, x10, e10);
      mstep(16, n16, p16, x16, e16);
      #1;
      chk("tc10", int'(tc_10), int'(e10));
      chk("tc16", int'(tc_16), int'(e16));
      chk("t10", int'(dut10.t), c10 ^ n10);
      chk("t16", int'(dut16.t), c16 ^ n16);
      @(posedge clk);
      c10 = n10; o10 = p10; w10 = x10;
      c16 = n16; o16 = p16; w16 = x16;
      #1;
      chk("count10", int'(count_10), c10);
      chk("wrap10",  int'(wrap_10),  int'(w10));
      chk("ovf10",   int'(ovf_10),   int'(o10));
      chk("count16", int'(count_16), c16);
      chk("wrap16",  int'(wrap_16),  int'(w16));
      chk("ovf16",   int'(ovf_16),   int'(o16));
      @(negedge clk);
   endtask

   task automatic set_in(input bit e, input bit u, input bit ld, input int lv,
                         input bit cl, input bit oc);
      en = e; up_dn = u; load = ld; load_val = 4'(lv); clr = cl; ovf_clr = oc;
   endtask

   task automatic add(input bit e, input bit u, input bit ld, input int lv,
                      input bit cl, input bit oc, input int ec,
                      input bit etc, input bit ew, input bit eo);
      vec_t v;
      v.en = e; v.up = u; v.ld = ld; v.lv = lv; v.clr = cl; v.oc = oc;
      v.ec = ec; v.etc = etc; v.ew = ew; v.eo = eo;
      tbl.push_back(v);
   endtask

   task automatic model_reset();
      c10 = 0; c16 = 0; o10 = 0; o16 = 0; w10 = 0; w16 = 0;
   endtask

   initial begin
      // Test 2: up from 0 for 12 edges, wrap at 9 -> 0
      for (int k = 0; k < 12; k++)
         add(1, 1, 0, 0, 0, 0, (k + 1) % 10, k == 9, k == 9, k >= 9);
      add(0, 1, 0, 0, 0, 1, 2, 0, 0, 0);   // ovf_clr alone
      // Test 3: down wrap 1,0,9,8
      add(0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 9, 1, 1, 1);
      add(1, 0, 0, 0, 0, 0, 8, 0, 0, 1);
      add(0, 0, 0, 0, 0, 1, 8, 0, 0, 0);
      add(0, 0, 0, 0, 0, 1, 8, 0, 0, 0);   // ovf_clr with no wrap keeps 0
      // Test 4: priority and clamp
      add(0, 0, 1, 5, 0, 0, 5, 0, 0, 0);
      add(1, 1, 1, 7, 1, 0, 0, 0, 0, 0);   // clr beats load and en
      add(0, 1, 1, 13, 0, 0, 9, 0, 0, 0);  // clamped
      add(1, 1, 1, 3, 0, 0, 3, 0, 0, 0);   // load beats en
      add(0, 0, 1, 15, 0, 0, 9, 0, 0, 0);
      // Test 5: wrap coinciding with ovf_clr -> set wins
      add(1, 1, 0, 0, 0, 1, 0, 1, 1, 1);
      add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);   // clr at 0 going down: no wrap

      // Reset state
      set_in(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      model_reset();
      #3;
      chk("rst_count", int'(count_10), 0);
      chk("rst_wrap",  int'(wrap_10),  0);
      chk("rst_ovf",   int'(ovf_10),   0);
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: first count after release, then async reset mid-count at 7
      set_in(1, 1, 0, 0, 0, 0);
      step();
      chk("first_count", int'(count_10), 1);
      for (int k = 0; k < 6; k++) step();
      chk("pre_reset_count", int'(count_10), 7);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_count", int'(count_10), 0);
      chk("async_rst_wrap",  int'(wrap_10),  0);
      chk("async_rst_ovf",   int'(ovf_10),   0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);

      // Table vectors (MODULUS=10 expectations; both models also check)
      foreach (tbl[i]) begin
         set_in(tbl[i].en, tbl[i].up, tbl[i].ld, tbl[i].lv, tbl[i].clr, tbl[i].oc);
         #1;
         chk($sformatf("vec%0d_tc", i), int'(tc_10), int'(tbl[i].etc));
         step();
         chk($sformatf("vec%0d_count", i), int'(count_10), tbl[i].ec);
         chk($sformatf("vec%0d_wrap", i),  int'(wrap_10),  int'(tbl[i].ew));
         chk($sformatf("vec%0d_ovf", i),   int'(ovf_10),   int'(tbl[i].eo));
      end

      // Test 6: power-of-two rollover 15 -> 0
      set_in(0, 1, 1, 15, 0, 1);
      step();
      chk("p2_load", int'(count_16), 15);
      set_in(1, 1, 0, 0, 0, 0);
      step();
      chk("p2_roll_count", int'(count_16), 0);
      chk("p2_roll_wrap",  int'(wrap_16),  1);

      // Random traffic against the models
      for (int k = 0; k < 1000; k++) begin
         set_in(($urandom % 4) != 0, $urandom % 2, ($urandom % 16) == 0,
                int'($urandom % 16), ($urandom % 32) == 0, ($urandom % 8) == 0);
         step();
      end

      // Reset drops a set ovf flag
      set_in(0, 0, 0, 0, 1, 0);
      step();
      set_in(1, 0, 0, 0, 0, 0);
      step();
      chk("ovf_before_rst", int'(ovf_10), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ovf_lost_rst",   int'(ovf_10),   0);
      chk("count_lost_rst", int'(count_16), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
